// File: rtl/fre_gate_ctrl.sv
// fre_gate_ctrl: auto-ranging gated edge counter for the frequency meter.
// Opens a per-range gate, counts input rising edges, steps range in EVAL, hands results out valid/ready.
module fre_gate_ctrl #(
    parameter int GATE_CYC0 = 50_000_000,
    parameter int GATE_CYC1 = 5_000_000,
    parameter int GATE_CYC2 = 500_000,
    parameter int HI_LIM    = 999_999,
    parameter int LO_LIM    = 99_999,
    parameter int CNT_W     = 24
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             fre_i,
    input  logic             en_i,
    output logic             gate_o,
    output logic [1:0]       range_o,
    output logic [CNT_W-1:0] res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             ovf_o
);
    localparam int TW = $clog2(GATE_CYC0 + 1);
    localparam logic [CNT_W-1:0] HI = CNT_W'(HI_LIM);
    localparam logic [CNT_W-1:0] LO = CNT_W'(LO_LIM);

    typedef enum logic [1:0] {IDLE, GATE, EVAL, OUT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [TW-1:0]    tmr_q, tmr_d, len;
    logic [CNT_W-1:0] cnt_q, cnt_d, res_q, res_d;
    logic [1:0]       range_q, range_d;
    logic             ovf_q, ovf_d, rise;

    assign rise = sync_q[1] & ~sync_q[2];
    assign len  = range_q == 2'd0 ? TW'(GATE_CYC0) : range_q == 2'd1 ? TW'(GATE_CYC1) : TW'(GATE_CYC2);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        range_d = range_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: state_d = en_i ? GATE : IDLE;
            GATE: begin
                tmr_d = tmr_q + 1'b1;
                cnt_d = (rise && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tmr_q == len - 1'b1) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q > HI && range_q < 2'd2) begin
                    range_d = range_q + 2'd1;
                    state_d = GATE;
                end else if (cnt_q < LO && range_q > 2'd0) begin
                    range_d = range_q - 2'd1;
                    state_d = GATE;
                end else begin
                    res_d   = cnt_q;
                    ovf_d   = cnt_q > HI;
                    state_d = OUT;
                end
            end
            OUT: if (res_ready_i) state_d = en_i ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
        // every entry into GATE starts a fresh window and count
        if (state_d == GATE && state_q != GATE) begin
            tmr_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            range_q <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], fre_i};
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            range_q <= range_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gate_o      = state_q == GATE;
    assign res_valid_o = state_q == OUT;
    assign range_o     = range_q;
    assign res_o       = res_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_fre_gate_ctrl.sv
// tb_fre_gate_ctrl: directed bench for fre_gate_ctrl with scaled-down gates.
// Instance a uses the normal limits; instance b uses tight limits to reach overflow at range 2.
module tb_fre_gate_ctrl;
    logic clk = 0, rst_n = 0, fre = 0, en = 0, rdy = 0, en2 = 0, rdy2 = 0;
    logic gate, vld, ovf, gate2, vld2, ovf2;
    logic [1:0] rng, rng2;
    logic [15:0] res, res2;
    int half = 0, ph = 0, vecs = 0, errs = 0;

    always #10 clk = ~clk;

    // fre toggles every 'half' clocks, 3 ns after the clock edge; half=0 parks it low
    always @(posedge clk) begin
        #3;
        if (half == 0) begin
            fre = 0;
            ph = 0;
        end else begin
            ph = ph + 1;
            if (ph >= half) begin
                fre = ~fre;
                ph = 0;
            end
        end
    end

    fre_gate_ctrl #(.GATE_CYC0(10000), .GATE_CYC1(1000), .GATE_CYC2(100),
                    .HI_LIM(999), .LO_LIM(99), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .fre_i(fre), .en_i(en), .gate_o(gate), .range_o(rng),
        .res_o(res), .res_valid_o(vld), .res_ready_i(rdy), .ovf_o(ovf));

    fre_gate_ctrl #(.GATE_CYC0(10000), .GATE_CYC1(1000), .GATE_CYC2(100),
                    .HI_LIM(40), .LO_LIM(4), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .fre_i(fre), .en_i(en2), .gate_o(gate2), .range_o(rng2),
        .res_o(res2), .res_valid_o(vld2), .res_ready_i(rdy2), .ovf_o(ovf2));

    task automatic gate_len(output int n);
        n = 0;
        while (gate === 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic accept;
        rdy = 1;
        @(negedge clk);
        rdy = 0;
        vecs++;
        if (vld !== 1'b0 || gate !== 1'b1) begin
            errs++;
            $display("FAIL accept: valid=%b gate=%b, want valid=0 gate=1", vld, gate);
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 0; en = 0; half = 3;
        repeat (95) @(negedge clk);
        vecs++;
        if ({gate, rng, res, vld, ovf} !== '0) begin
            errs++;
            $display("FAIL reset_a: gate=%b range=%0d res=%0d valid=%b ovf=%b, want all 0", gate, rng, res, vld, ovf);
        end
        vecs++;
        if ({gate2, rng2, res2, vld2, ovf2} !== '0) begin
            errs++;
            $display("FAIL reset_b: gate=%b range=%0d res=%0d valid=%b ovf=%b, want all 0", gate2, rng2, res2, vld2, ovf2);
        end
        half = 0;
        repeat (5) @(negedge clk);
        en = 1; rst_n = 1; half = 480;
        @(negedge clk);
        vecs++;
        if (gate !== 1'b1) begin
            errs++;
            $display("FAIL gate_rise: gate=%b, want 1", gate);
        end
        gate_len(n);
        vecs++;
        if (n != 10000) begin
            errs++;
            $display("FAIL gate_len_r0: got %0d cycles, want 10000", n);
        end
    endtask

    task automatic test_range0;
        vecs++;
        if (vld !== 1'b0) begin
            errs++;
            $display("FAIL valid_early: valid=%b in EVAL, want 0", vld);
        end
        @(negedge clk);
        vecs++;
        if (vld !== 1'b1 || !(res inside {16'd10, 16'd11}) || rng !== 2'd0 || ovf !== 1'b0) begin
            errs++;
            $display("FAIL res_r0: valid=%b res=%0d range=%0d ovf=%b, want 1 10..11 0 0", vld, res, rng, ovf);
        end
    endtask

    task automatic test_handshake;
        logic [15:0] held;
        held = res;
        rdy = 0;
        repeat (50) begin
            @(negedge clk);
            vecs++;
            if (vld !== 1'b1 || res !== held || gate !== 1'b0) begin
                errs++;
                $display("FAIL hold: valid=%b res=%0d gate=%b, want 1 %0d 0", vld, res, gate, held);
            end
        end
        accept();
    endtask

    task automatic test_range_switch;
        int n;
        half = 2;
        gate_len(n);
        vecs++;
        if (n != 10000 || vld !== 1'b0) begin
            errs++;
            $display("FAIL discard_up: len=%0d valid=%b, want 10000 0", n, vld);
        end
        @(negedge clk);
        vecs++;
        if (gate !== 1'b1 || rng !== 2'd1 || vld !== 1'b0) begin
            errs++;
            $display("FAIL range_up: gate=%b range=%0d valid=%b, want 1 1 0", gate, rng, vld);
        end
        gate_len(n);
        vecs++;
        if (n != 1000) begin
            errs++;
            $display("FAIL gate_len_r1: got %0d cycles, want 1000", n);
        end
        @(negedge clk);
        vecs++;
        if (vld !== 1'b1 || res < 16'd249 || res > 16'd251 || ovf !== 1'b0 || rng !== 2'd1) begin
            errs++;
            $display("FAIL res_r1: valid=%b res=%0d ovf=%b range=%0d, want 1 249..251 0 1", vld, res, ovf, rng);
        end
        half = 480;
        accept();
        gate_len(n);
        vecs++;
        if (n != 1000 || vld !== 1'b0) begin
            errs++;
            $display("FAIL discard_down: len=%0d valid=%b, want 1000 0", n, vld);
        end
        @(negedge clk);
        vecs++;
        if (gate !== 1'b1 || rng !== 2'd0 || vld !== 1'b0) begin
            errs++;
            $display("FAIL range_down: gate=%b range=%0d valid=%b, want 1 0 0", gate, rng, vld);
        end
        gate_len(n);
        @(negedge clk);
        vecs++;
        if (n != 10000 || vld !== 1'b1 || !(res inside {16'd10, 16'd11}) || rng !== 2'd0) begin
            errs++;
            $display("FAIL res_back_r0: len=%0d valid=%b res=%0d range=%0d, want 10000 1 10..11 0", n, vld, res, rng);
        end
        accept();
    endtask

    task automatic test_abort;
        int n;
        repeat (4999) @(negedge clk);
        vecs++;
        if (gate !== 1'b1) begin
            errs++;
            $display("FAIL gate_mid: gate=%b at cycle 5000, want 1", gate);
        end
        en = 0;
        @(negedge clk);
        vecs++;
        if (gate !== 1'b0) begin
            errs++;
            $display("FAIL abort_gate: gate=%b, want 0", gate);
        end
        repeat (20) begin
            @(negedge clk);
            vecs++;
            if (vld !== 1'b0 || gate !== 1'b0) begin
                errs++;
                $display("FAIL abort_idle: valid=%b gate=%b, want 0 0", vld, gate);
            end
        end
        en = 1;
        @(negedge clk);
        vecs++;
        if (gate !== 1'b1) begin
            errs++;
            $display("FAIL reenable: gate=%b, want 1", gate);
        end
        gate_len(n);
        @(negedge clk);
        vecs++;
        if (n != 10000 || vld !== 1'b1 || !(res inside {16'd10, 16'd11})) begin
            errs++;
            $display("FAIL res_after_abort: len=%0d valid=%b res=%0d, want 10000 1 10..11", n, vld, res);
        end
        accept();
    endtask

    task automatic test_reset_mid;
        int n;
        half = 2;
        gate_len(n);
        @(negedge clk);
        vecs++;
        if (gate !== 1'b1 || rng !== 2'd1) begin
            errs++;
            $display("FAIL pre_reset: gate=%b range=%0d, want 1 1", gate, rng);
        end
        repeat (500) @(negedge clk);
        #5 rst_n = 0;
        #1;
        vecs++;
        if ({gate, rng, res, vld, ovf} !== '0) begin
            errs++;
            $display("FAIL reset_mid: gate=%b range=%0d res=%0d valid=%b ovf=%b, want all 0", gate, rng, res, vld, ovf);
        end
    endtask

    task automatic test_overflow;
        int n;
        bit seen1;
        n = 0; seen1 = 0;
        en = 0; en2 = 1; rdy2 = 0; half = 1;
        @(negedge clk);
        rst_n = 1;
        while (vld2 !== 1'b1 && n < 12000) begin
            @(negedge clk);
            n++;
            if (rng2 === 2'd1) seen1 = 1;
        end
        vecs++;
        if (vld2 !== 1'b1) begin
            errs++;
            $display("FAIL ovf_timeout: valid=%b after %0d cycles, want 1", vld2, n);
        end
        vecs++;
        if (!seen1 || rng2 !== 2'd2 || n < 11000) begin
            errs++;
            $display("FAIL ovf_ranges: seen_r1=%0d range=%0d cycles=%0d, want 1 2 >=11000", seen1, rng2, n);
        end
        vecs++;
        if (res2 < 16'd49 || res2 > 16'd51 || ovf2 !== 1'b1) begin
            errs++;
            $display("FAIL ovf_res: res=%0d ovf=%b, want 49..51 1", res2, ovf2);
        end
        vecs++;
        if (gate !== 1'b0 || vld !== 1'b0) begin
            errs++;
            $display("FAIL a_idle: gate=%b valid=%b, want 0 0", gate, vld);
        end
    endtask

    initial begin
        test_reset();
        test_range0();
        test_handshake();
        test_range_switch();
        test_abort();
        test_reset_mid();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
